debug_dump_sequencer: RTL and testbench

DEBUG_DUMP_SEQUENCER -- requirements
Module: debug_dump_sequencer

---
 rtl/debug_dump_sequencer_pkg.sv | 19 +
 rtl/dump_byte_select.sv | 18 +
 rtl/debug_dump_sequencer.sv | 119 +++++++++++
 tb/tb_debug_dump_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_dump_sequencer_pkg.sv
// Shared definitions for the debug dump path: FSM encoding and frame/timeout defaults.
package debug_dump_sequencer_pkg;

  localparam int DATA_BYTES_DEFAULT = 320;
  localparam int TX_TIMEOUT_DEFAULT = 65535;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD = 3'd1;
  localparam logic [STATE_W-1:0] ST_SEND = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE = 3'd4;

  // A one-byte frame still needs a 1-bit index to stay a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dump_byte_select.sv
// Combinational byte mux: picks byte[index] out of the captured dump frame.
module dump_byte_select #(
  parameter int DATA_BYTES = 4,
  parameter int IDX_W      = 2
) (
  input  logic [8*DATA_BYTES-1:0] frame,
  input  logic [IDX_W-1:0]        index,
  output logic [7:0]              byte_out
);

  always_comb begin
    byte_out = 8'h00;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (index == IDX_W'(k)) byte_out = frame[8*k +: 8];
    end
  end

endmodule

// File: rtl/debug_dump_sequencer.sv
// Streams a captured debug snapshot byte-by-byte into a UART transmitter, LSB byte first.
module debug_dump_sequencer
  import debug_dump_sequencer_pkg::*;
#(
  parameter int DATA_BYTES = DATA_BYTES_DEFAULT,
  parameter int TX_TIMEOUT = TX_TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [8*DATA_BYTES-1:0] i_data_bus,
  input  logic                    i_tx_done,
  output logic [7:0]              o_data_send,
  output logic                    o_tx_start,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_timeout,
  output logic [STATE_W-1:0]      o_dbg_state
);

  // Handshake: o_tx_start is a single-cycle request for o_data_send; the
  // transmitter answers with a single-cycle i_tx_done, honoured only in WAIT.

  localparam int IDX_W = idx_width(DATA_BYTES);
  localparam int TMO_W = $clog2(TX_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TX_TIMEOUT);

  logic [STATE_W-1:0]      state;
  logic [STATE_W-1:0]      next_state;
  logic [IDX_W-1:0]        index;
  logic [8*DATA_BYTES-1:0] frame;
  logic [TMO_W-1:0]        tmo_cnt;
  logic [7:0]              sel_byte;
  logic                    capture;
  logic                    advance;
  logic                    tmo_hit;

  dump_byte_select #(
    .DATA_BYTES(DATA_BYTES),
    .IDX_W     (IDX_W)
  ) u_byte_select (
    .frame   (frame),
    .index   (index),
    .byte_out(sel_byte)
  );

  // Abort wins over tx_done and timeout; start with abort in IDLE is dropped.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    advance    = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          capture    = 1'b1;
          next_state = ST_LOAD;
        end
      end
      ST_LOAD: next_state = i_abort ? ST_IDLE : ST_SEND;
      ST_SEND: next_state = i_abort ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (i_abort) begin
          next_state = ST_IDLE;
        end else if (i_tx_done) begin
          if (index == LAST_IDX) begin
            next_state = ST_DONE;
          end else begin
            advance    = 1'b1;
            next_state = ST_LOAD;
          end
        end else if (tmo_cnt == TMO_LIMIT) begin
          tmo_hit    = 1'b1;
          next_state = ST_IDLE;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          frame <= '0;
    else if (capture) frame <= i_data_bus;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          index <= '0;
    else if (capture) index <= '0;
    else if (advance) index <= index + IDX_W'(1);
  end

  // Counts WAIT cycles for the current byte; saturates so it cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        tmo_cnt <= '0;
    else if (state == ST_SEND)                      tmo_cnt <= '0;
    else if (state == ST_WAIT && tmo_cnt != TMO_LIMIT) tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  // Outputs decode the registered state, so reset clears them asynchronously.
  always_comb begin
    o_data_send = 8'h00;
    if (state == ST_LOAD || state == ST_SEND || state == ST_WAIT) o_data_send = sel_byte;
  end

  assign o_tx_start  = (state == ST_SEND) && !i_abort;
  assign o_done      = (state == ST_DONE) && !i_abort;
  assign o_timeout   = tmo_hit;
  assign o_busy      = (state != ST_IDLE);
  assign o_dbg_state = state;

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Scoreboarded bench: a 4-byte instance for protocol corners, a 320-byte instance for a full frame.
module tb_debug_dump_sequencer;
  import debug_dump_sequencer_pkg::*;

  localparam int A_BYTES = 4;
  localparam int A_TMO   = 8;
  localparam int B_BYTES = 320;
  localparam int B_TMO   = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT A (4 bytes) ----------------
  logic                 a_start, a_abort, a_tx_done;
  logic [8*A_BYTES-1:0] a_bus;
  logic [7:0]           a_data;
  logic                 a_tx_start, a_busy, a_done, a_timeout;
  logic [STATE_W-1:0]   a_state;

  debug_dump_sequencer #(.DATA_BYTES(A_BYTES), .TX_TIMEOUT(A_TMO)) u_dut_a (
    .clk(clk), .rst(rst), .i_start(a_start), .i_abort(a_abort),
    .i_data_bus(a_bus), .i_tx_done(a_tx_done), .o_data_send(a_data),
    .o_tx_start(a_tx_start), .o_busy(a_busy), .o_done(a_done),
    .o_timeout(a_timeout), .o_dbg_state(a_state)
  );

  // ---------------- DUT B (320 bytes) ----------------
  logic                 b_start, b_abort, b_tx_done;
  logic [8*B_BYTES-1:0] b_bus;
  logic [7:0]           b_data;
  logic                 b_tx_start, b_busy, b_done, b_timeout;
  logic [STATE_W-1:0]   b_state;

  debug_dump_sequencer #(.DATA_BYTES(B_BYTES), .TX_TIMEOUT(B_TMO)) u_dut_b (
    .clk(clk), .rst(rst), .i_start(b_start), .i_abort(b_abort),
    .i_data_bus(b_bus), .i_tx_done(b_tx_done), .o_data_send(b_data),
    .o_tx_start(b_tx_start), .o_busy(b_busy), .o_done(b_done),
    .o_timeout(b_timeout), .o_dbg_state(b_state)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_a_q[$];
  logic [7:0] exp_b_q[$];
  int         a_done_cnt = 0;
  int         a_tmo_cnt  = 0;
  int         b_tx_cnt   = 0;
  int         b_done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every transmit request must match the next expected byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_tx_start) begin
        if (exp_a_q.size() == 0) check("a_unexpected_tx_start", 32'd1, 32'd0);
        else                     check("a_byte", {24'h0, a_data}, {24'h0, exp_a_q.pop_front()});
      end
      if (a_done)    a_done_cnt++;
      if (a_timeout) a_tmo_cnt++;
      if (b_tx_start) begin
        b_tx_cnt++;
        if (exp_b_q.size() == 0) check("b_unexpected_tx_start", 32'd1, 32'd0);
        else                     check("b_byte", {24'h0, b_data}, {24'h0, exp_b_q.pop_front()});
      end
      if (b_done) b_done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_a(input logic [31:0] bus, input int n);
    for (int k = 0; k < n; k++) exp_a_q.push_back(bus[8*k +: 8]);
  endtask

  task automatic a_pulse_start(input logic [31:0] bus);
    a_bus   = bus;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  // Returns the number of negedges until o_tx_start is seen (bounded).
  task automatic a_wait_tx(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!a_tx_start && cyc < 100);
    if (!a_tx_start) check("a_tx_start_wait", 32'd0, 32'd1);
  endtask

  task automatic a_serve(input int nbytes, input int restart_at, input int abort_at);
    int         cyc;
    logic [7:0] held;
    for (int b = 0; b < nbytes; b++) begin
      a_wait_tx(cyc);
      check("a_latency", cyc, 32'd2);
      if (!a_tx_start) return;
      held = a_data;
      @(posedge clk); #1;
      if (b == restart_at) begin
        a_bus   = 32'h44332211;
        a_start = 1'b1;
      end
      @(posedge clk); #1;
      a_start = 1'b0;
      @(posedge clk); #1;
      check("a_hold", {24'h0, a_data}, {24'h0, held});
      a_tx_done = 1'b1;
      if (b == abort_at) a_abort = 1'b1;
      @(posedge clk); #1;
      a_tx_done = 1'b0;
      a_abort   = 1'b0;
      if (b == abort_at) return;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int done_base;
    rst = 1'b1;
    a_start = 1'b0; a_abort = 1'b0; a_tx_done = 1'b0; a_bus = '0;
    b_start = 1'b0; b_abort = 1'b0; b_tx_done = 1'b0; b_bus = '0;

    // Reset state
    @(negedge clk);
    check("rst_data",    {24'h0, a_data}, 32'h0);
    check("rst_tx",      {31'h0, a_tx_start}, 32'h0);
    check("rst_busy",    {31'h0, a_busy}, 32'h0);
    check("rst_done",    {31'h0, a_done}, 32'h0);
    check("rst_timeout", {31'h0, a_timeout}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Basic 4-byte dump
    push_a(32'hDDCCBBAA, 4);
    done_base = a_done_cnt;
    a_pulse_start(32'hDDCCBBAA);
    a_serve(4, -1, -1);
    @(posedge clk); #1;
    check("basic_done_cnt", a_done_cnt - done_base, 32'd1);
    check("basic_busy_low", {31'h0, a_busy}, 32'h0);

    // Restart during byte 2 must not recapture
    push_a(32'hDDCCBBAA, 4);
    done_base = a_done_cnt;
    a_pulse_start(32'hDDCCBBAA);
    a_serve(4, 2, -1);
    @(posedge clk); #1;
    check("restart_done_cnt", a_done_cnt - done_base, 32'd1);
    check("restart_q_empty", exp_a_q.size(), 32'd0);

    // Abort together with tx_done during byte 1
    push_a(32'hDDCCBBAA, 2);
    done_base = a_done_cnt;
    a_pulse_start(32'hDDCCBBAA);
    a_serve(2, -1, 1);
    check("abort_state", {29'h0, a_state}, {29'h0, ST_IDLE});
    check("abort_busy", {31'h0, a_busy}, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", a_done_cnt - done_base, 32'd0);

    // Timeout with no tx_done
    push_a(32'hDDCCBBAA, 1);
    done_base = a_done_cnt;
    a_pulse_start(32'hDDCCBBAA);
    a_wait_tx(cyc);
    check("tmo_latency", cyc, 32'd2);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!a_timeout && cyc < 50);
    check("tmo_cycles", cyc, 32'd9);
    @(posedge clk); #1;
    check("tmo_state", {29'h0, a_state}, {29'h0, ST_IDLE});
    check("tmo_pulses", a_tmo_cnt, 32'd1);
    check("tmo_no_done", a_done_cnt - done_base, 32'd0);

    // Asynchronous reset mid byte 2, then a fresh dump from byte 0
    push_a(32'hDDCCBBAA, 3);
    a_pulse_start(32'hDDCCBBAA);
    a_serve(2, -1, -1);
    a_wait_tx(cyc);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_data",  {24'h0, a_data}, 32'h0);
    check("arst_busy",  {31'h0, a_busy}, 32'h0);
    check("arst_tx",    {31'h0, a_tx_start}, 32'h0);
    check("arst_done",  {31'h0, a_done}, 32'h0);
    check("arst_tmo",   {31'h0, a_timeout}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    push_a(32'h87654321, 4);
    done_base = a_done_cnt;
    a_pulse_start(32'h87654321);
    a_serve(4, -1, -1);
    @(posedge clk); #1;
    check("post_rst_done_cnt", a_done_cnt - done_base, 32'd1);

    // start+abort together in IDLE, and stray tx_done in IDLE: nothing happens
    a_bus = 32'h01020304;
    a_start = 1'b1; a_abort = 1'b1; a_tx_done = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0; a_abort = 1'b0; a_tx_done = 1'b0;
    check("idle_start_abort_state", {29'h0, a_state}, {29'h0, ST_IDLE});
    repeat (10) @(posedge clk);
    #1;
    check("idle_start_abort_busy", {31'h0, a_busy}, 32'h0);
    check("a_q_empty", exp_a_q.size(), 32'd0);

    // Full 320-byte frame on instance B
    for (int k = 0; k < B_BYTES; k++) begin
      b_bus[8*k +: 8] = 8'(k);
      exp_b_q.push_back(8'(k));
    end
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int k = 0; k < B_BYTES; k++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!b_tx_start && cyc < 100);
      if (!b_tx_start) begin
        check("b_tx_start_wait", 32'd0, 32'd1);
        break;
      end
      @(posedge clk); #1;
      b_tx_done = 1'b1;
      @(posedge clk); #1;
      b_tx_done = 1'b0;
    end
    @(posedge clk); #1;
    check("b_tx_count", b_tx_cnt, B_BYTES);
    check("b_done_cnt", b_done_cnt, 32'd1);
    check("b_q_empty", exp_b_q.size(), 32'd0);
    check("b_busy_low", {31'h0, b_busy}, 32'h0);
    check("b_no_timeout", {31'h0, b_timeout}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
